// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative divider: FSM encodings, default width
// and the radix choices the datapath supports.
package iter_divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 32;

    localparam int UNROLL_R1 = 1;
    localparam int UNROLL_R2 = 2;
    localparam int UNROLL_R4 = 4;

    function automatic bit unroll_legal(input int unroll);
        return (unroll == UNROLL_R1) || (unroll == UNROLL_R2) || (unroll == UNROLL_R4);
    endfunction

endpackage

// File: rtl/iter_divider_div_step.sv
// One combinational restoring-division step: shift the partial remainder,
// bring in the next dividend bit, subtract the divisor when it fits.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] divisor,
    input  logic             dividend_bit,
    output logic [WIDTH-1:0] rem_out,
    output logic             quot_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    // shifted < 2*divisor, so the WIDTH+1-bit difference's msb is its sign
    always_comb begin
        shifted  = {rem_in, dividend_bit};
        diff     = shifted - {1'b0, divisor};
        quot_bit = ~diff[WIDTH];
        rem_out  = quot_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/iter_divider.sv
// Multi-cycle signed/unsigned integer divider with valid/ready handshakes,
// flush, UNROLL quotient bits per cycle and defined divide-by-zero results.
module iter_divider
    import iter_divider_pkg::*;
#(
    parameter int WIDTH  = DEFAULT_WIDTH,
    parameter int UNROLL = 1
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             cancel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_signed,
    input  logic [WIDTH-1:0] in_op1,
    input  logic [WIDTH-1:0] in_op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_quotient,
    output logic [WIDTH-1:0] out_remainder,
    output logic             out_div_zero
);

    localparam int ITERS = WIDTH / UNROLL;
    localparam int CNT_W = $clog2(ITERS + 1);

    if (!unroll_legal(UNROLL) || (WIDTH % UNROLL) != 0 || (WIDTH % 2) != 0 || WIDTH < 4) begin : g_bad_cfg
        $error("iter_divider: illegal WIDTH=%0d / UNROLL=%0d", WIDTH, UNROLL);
    end

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [WIDTH-1:0]   dq_q, dq_d;       // dividend shifts out the top, quotient fills the bottom
    logic [WIDTH-1:0]   dvs_q, dvs_d;
    logic               qsign_q, qsign_d;
    logic               rsign_q, rsign_d;
    logic               dz_q, dz_d;
    logic [WIDTH-1:0]   out_quotient_q, out_quotient_d;
    logic [WIDTH-1:0]   out_remainder_q, out_remainder_d;
    logic               out_div_zero_q, out_div_zero_d;

    logic [WIDTH-1:0]   rem_c [UNROLL+1];
    logic [WIDTH-1:0]   dq_c  [UNROLL+1];
    logic [UNROLL-1:0]  qbit_c;

    assign rem_c[0] = rem_q;
    assign dq_c[0]  = dq_q;

    for (genvar gi = 0; gi < UNROLL; gi++) begin : g_step
        div_step #(.WIDTH(WIDTH)) u_step (
            .rem_in       (rem_c[gi]),
            .divisor      (dvs_q),
            .dividend_bit (dq_c[gi][WIDTH-1]),
            .rem_out      (rem_c[gi+1]),
            .quot_bit     (qbit_c[gi])
        );
        assign dq_c[gi+1] = {dq_c[gi][WIDTH-2:0], qbit_c[gi]};
    end

    logic             neg1, neg2;
    logic [WIDTH-1:0] abs1, abs2;

    assign in_ready      = (state_q == ST_IDLE) & ~cancel;
    assign out_valid     = (state_q == ST_DONE);
    assign out_quotient  = out_quotient_q;
    assign out_remainder = out_remainder_q;
    assign out_div_zero  = out_div_zero_q;

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        rem_d           = rem_q;
        dq_d            = dq_q;
        dvs_d           = dvs_q;
        qsign_d         = qsign_q;
        rsign_d         = rsign_q;
        dz_d            = dz_q;
        out_quotient_d  = out_quotient_q;
        out_remainder_d = out_remainder_q;
        out_div_zero_d  = out_div_zero_q;

        neg1 = in_signed & in_op1[WIDTH-1];
        neg2 = in_signed & in_op2[WIDTH-1];
        abs1 = neg1 ? -in_op1 : in_op1;
        abs2 = neg2 ? -in_op2 : in_op2;

        case (state_q)
            ST_IDLE: begin
                if (in_valid && in_ready) begin
                    dvs_d   = abs2;
                    rem_d   = '0;
                    qsign_d = neg1 ^ neg2;
                    rsign_d = neg1;
                    dz_d    = (in_op2 == '0);
                    state_d = ST_CALC;
                    // A zero divisor skips the iterations and keeps the raw dividend for the remainder
                    if (in_op2 == '0) begin
                        dq_d  = in_op1;
                        cnt_d = '0;
                    end else begin
                        dq_d  = abs1;
                        cnt_d = CNT_W'(ITERS);
                    end
                end
            end
            ST_CALC: begin
                if (cnt_q != '0) begin
                    rem_d = rem_c[UNROLL];
                    dq_d  = dq_c[UNROLL];
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    out_quotient_d  = dz_q ? '1   : (qsign_q ? -dq_q  : dq_q);
                    out_remainder_d = dz_q ? dq_q : (rsign_q ? -rem_q : rem_q);
                    out_div_zero_d  = dz_q;
                    state_d         = ST_DONE;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cancel) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            rem_q           <= '0;
            dq_q            <= '0;
            dvs_q           <= '0;
            qsign_q         <= 1'b0;
            rsign_q         <= 1'b0;
            dz_q            <= 1'b0;
            out_quotient_q  <= '0;
            out_remainder_q <= '0;
            out_div_zero_q  <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            rem_q           <= rem_d;
            dq_q            <= dq_d;
            dvs_q           <= dvs_d;
            qsign_q         <= qsign_d;
            rsign_q         <= rsign_d;
            dz_q            <= dz_d;
            out_quotient_q  <= out_quotient_d;
            out_remainder_q <= out_remainder_d;
            out_div_zero_q  <= out_div_zero_d;
        end
    end

endmodule

// File: tb/tb_iter_divider.sv
// Scoreboard bench for iter_divider at UNROLL 1, 2 and 4 with hand-computed vectors.
module tb_iter_divider;

    localparam int W = 32;

    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    logic         cancel    [3];
    logic         in_valid  [3];
    logic         in_ready  [3];
    logic         in_signed [3];
    logic [W-1:0] in_op1    [3];
    logic [W-1:0] in_op2    [3];
    logic         out_valid [3];
    logic         out_ready [3];
    logic [W-1:0] out_q     [3];
    logic [W-1:0] out_r     [3];
    logic         out_z     [3];

    iter_divider #(.WIDTH(W), .UNROLL(1)) u_div1 (
        .clk(clk), .resetn(resetn), .cancel(cancel[0]), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
        .in_signed(in_signed[0]), .in_op1(in_op1[0]), .in_op2(in_op2[0]), .out_valid(out_valid[0]),
        .out_ready(out_ready[0]), .out_quotient(out_q[0]), .out_remainder(out_r[0]), .out_div_zero(out_z[0])
    );
    iter_divider #(.WIDTH(W), .UNROLL(2)) u_div2 (
        .clk(clk), .resetn(resetn), .cancel(cancel[1]), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
        .in_signed(in_signed[1]), .in_op1(in_op1[1]), .in_op2(in_op2[1]), .out_valid(out_valid[1]),
        .out_ready(out_ready[1]), .out_quotient(out_q[1]), .out_remainder(out_r[1]), .out_div_zero(out_z[1])
    );
    iter_divider #(.WIDTH(W), .UNROLL(4)) u_div4 (
        .clk(clk), .resetn(resetn), .cancel(cancel[2]), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
        .in_signed(in_signed[2]), .in_op1(in_op1[2]), .in_op2(in_op2[2]), .out_valid(out_valid[2]),
        .out_ready(out_ready[2]), .out_quotient(out_q[2]), .out_remainder(out_r[2]), .out_div_zero(out_z[2])
    );

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
        int          lat;
    } exp_t;

    typedef struct packed {
        logic        s;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        z;
    } vec_t;

    localparam int NVEC = 14;
    localparam vec_t VEC [NVEC] = '{
        '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0},
        '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0},
        '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0},
        '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0},
        '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1},
        '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1},
        '{1'b1, 32'hFFFF_FFF9,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF9,  1'b1},
        '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0},
        '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0},
        '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0},
        '{1'b0, 32'd7,          32'd100,        32'd0,          32'd7,          1'b0},
        '{1'b1, 32'h8000_0000,  32'd3,          32'hD555_5556,  32'hFFFF_FFFE,  1'b0},
        '{1'b0, 32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,          1'b0},
        '{1'b0, 32'hDEAD_BEEF,  32'h10,         32'h0DEA_DBEE,  32'hF,          1'b0}
    };

    exp_t sb [3][$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   acc  [3];
    bit   seen [3];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int un(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 4);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Monitor: latency at first out_valid, data compare at each output handshake
    initial begin
        exp_t e;
        for (int k = 0; k < 3; k++) begin
            acc[k]  = 0;
            seen[k] = 1'b0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                if (!out_valid[k]) begin
                    seen[k] = 1'b0;
                end else begin
                    if (sb[k].size() == 0) begin
                        if (!seen[k]) chk($sformatf("dut%0d unexpected_out_valid", k), 32'd1, 32'd0);
                        seen[k] = 1'b1;
                    end else begin
                        if (!seen[k]) chk($sformatf("dut%0d latency", k), 32'(cyc - acc[k]), 32'(sb[k][0].lat));
                        seen[k] = 1'b1;
                        if (out_ready[k]) begin
                            e = sb[k].pop_front();
                            chk($sformatf("dut%0d quotient", k),  out_q[k], e.q);
                            chk($sformatf("dut%0d remainder", k), out_r[k], e.r);
                            chk($sformatf("dut%0d div_zero", k),  32'(out_z[k]), 32'(e.z));
                            $display("txn dut%0d q=0x%08h r=0x%08h z=%0b", k, out_q[k], out_r[k], out_z[k]);
                        end
                    end
                end
                if (resetn && in_valid[k] && in_ready[k]) acc[k] = cyc + 1;
            end
        end
    end

    task automatic issue(input int k, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] q, input logic [31:0] r, input logic z, input bit push);
        exp_t e;
        int   n;
        @(posedge clk); #2;
        in_valid[k]  = 1'b1;
        in_signed[k] = s;
        in_op1[k]    = a;
        in_op2[k]    = b;
        if (push) begin
            e.q = q; e.r = r; e.z = z;
            e.lat = z ? 1 : (W / un(k) + 1);
            sb[k].push_back(e);
        end
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_ready[k] && n < 200);
        chk($sformatf("dut%0d accept", k), 32'(in_ready[k]), 32'd1);
        @(posedge clk); #2;
        in_valid[k] = 1'b0;
        in_op1[k]   = ~a;
        in_op2[k]   = ~b;
        in_signed[k] = ~s;
    endtask

    task automatic wait_drain(input int k);
        int n = 0;
        while (sb[k].size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("dut%0d drain", k), 32'(sb[k].size()), 32'd0);
    endtask

    task automatic wait_ov(input int k);
        int n = 0;
        while (!out_valid[k] && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk($sformatf("dut%0d wait_out_valid", k), 32'(out_valid[k]), 32'd1);
    endtask

    task automatic no_output(input int k, input string name);
        logic any = 1'b0;
        repeat (45) begin
            @(negedge clk);
            any = any | out_valid[k];
        end
        chk(name, 32'(any), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int k = 0; k < 3; k++) begin
            cancel[k] = 1'b0; in_valid[k] = 1'b0; in_signed[k] = 1'b0;
            in_op1[k] = '0; in_op2[k] = '0; out_ready[k] = 1'b1;
        end
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset out_valid",  32'(out_valid[0]), 32'd0);
        chk("reset quotient",   out_q[0], 32'd0);
        chk("reset remainder",  out_r[0], 32'd0);
        chk("reset div_zero",   32'(out_z[0]), 32'd0);
        @(posedge clk); #2;
        resetn = 1'b1;
        @(negedge clk);
        for (int k = 0; k < 3; k++) chk($sformatf("dut%0d reset in_ready", k), 32'(in_ready[k]), 32'd1);

        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < NVEC; i++) begin
                issue(k, VEC[i].s, VEC[i].a, VEC[i].b, VEC[i].q, VEC[i].r, VEC[i].z, 1'b1);
                wait_drain(k);
            end
        end

        // Back-pressure: result held in DONE, no new request taken
        @(posedge clk); #2;
        out_ready[0] = 1'b0;
        issue(0, 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b1);
        wait_ov(0);
        @(posedge clk); #2;
        in_valid[0] = 1'b1;
        in_op1[0] = 32'd9; in_op2[0] = 32'd3;
        repeat (5) begin
            @(negedge clk);
            chk("hold out_valid", 32'(out_valid[0]), 32'd1);
            chk("hold quotient",  out_q[0], 32'd14);
            chk("hold remainder", out_r[0], 32'd2);
            chk("hold in_ready",  32'(in_ready[0]), 32'd0);
        end
        @(posedge clk); #2;
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("post handshake in_ready", 32'(in_ready[0]), 32'd1);
        wait_drain(0);

        // Flush during CALC
        issue(0, 1'b0, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #2 cancel[0] = 1'b1;
        @(negedge clk);
        chk("cancel in_ready low", 32'(in_ready[0]), 32'd0);
        @(posedge clk); #2;
        cancel[0] = 1'b0;
        @(negedge clk);
        chk("cancel in_ready next", 32'(in_ready[0]), 32'd1);
        no_output(0, "cancel no out_valid");

        // Cancel coinciding with a request blocks acceptance
        @(posedge clk); #2;
        in_valid[0] = 1'b1; cancel[0] = 1'b1;
        in_signed[0] = 1'b0; in_op1[0] = 32'd100; in_op2[0] = 32'd7;
        @(negedge clk);
        chk("cancel+valid in_ready", 32'(in_ready[0]), 32'd0);
        @(posedge clk); #2;
        in_valid[0] = 1'b0; cancel[0] = 1'b0;
        no_output(0, "cancel+valid no out_valid");

        // Asynchronous reset mid-CALC
        issue(0, 1'b0, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
        repeat (9) @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        chk("midreset out_valid", 32'(out_valid[0]), 32'd0);
        chk("midreset quotient",  out_q[0], 32'd0);
        chk("midreset remainder", out_r[0], 32'd0);
        @(posedge clk); #2;
        resetn = 1'b1;
        @(negedge clk);
        chk("midreset in_ready", 32'(in_ready[0]), 32'd1);
        no_output(0, "midreset no out_valid");

        issue(0, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 1'b0, 1'b1);
        wait_drain(0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
